// File: rtl/mcu_spi_deframer_pkg.sv
// Shared types and constants for the MCU SPI deframer: frame states, target IDs
// and the byte width used throughout the SPI front end.
package mcu_spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TARGET  = 2'd1,
    ST_CMD     = 2'd2,
    ST_PAYLOAD = 2'd3
  } spi_state_e;

  localparam logic [7:0] TGT_SYS = 8'd0;
  localparam logic [7:0] TGT_HID = 8'd1;
  localparam logic [7:0] TGT_OSD = 8'd2;
  localparam logic [7:0] TGT_SDC = 8'd3;

  function automatic logic id_in_range(input logic [7:0] id, input int unsigned n);
    return ({24'd0, id} < n);
  endfunction

endpackage

// File: rtl/mcu_spi_deframer_if.sv
// SPI pin bundle between the IO MCU (master) and the FPGA deframer (slave).
interface mcu_spi_deframer_if;

  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sck,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );

endinterface

// File: rtl/mcu_spi_deframer_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI line, with rise/fall pulses
// derived from the synchronised value and its one-cycle delayed copy.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic dly_r;

  // Synchroniser chain plus edge-detect history flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      dly_r  <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  assign sync = sync_r;
  assign rise = sync_r & ~dly_r;
  assign fall = ~sync_r & dly_r;

endmodule

// File: rtl/mcu_spi_deframer.sv
// SPI slave deframer: first byte of a CS frame selects a target, the rest are
// strobed to it while its reply byte shifts out on MISO. Optional stall
// watchdog enabled by defining MCU_SPI_TIMEOUT_EN.
module mcu_spi_deframer
  import mcu_spi_pkg::*;
#(
  parameter int TARGETS     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clk,
  input  logic                        reset_n,
  mcu_spi_deframer_if.slave           spi,
  output logic [BYTE_W-1:0]           data_out,
  output logic [TARGETS-1:0]          data_in_strobe,
  output logic                        data_in_start,
  input  logic [BYTE_W*TARGETS-1:0]   target_din,
  output logic                        frame_active
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

  logic sck_s, sck_rise_s, sck_fall_s;
  logic cs_n_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .din(spi.spi_sck),
    .sync(sck_s), .rise(sck_rise_s), .fall(sck_fall_s)
  );

  // CS resets to the deasserted level so reset release never opens a frame.
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .din(spi.spi_cs_n),
    .sync(cs_n_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(spi.spi_mosi),
    .sync(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  logic unused_s;
  assign unused_s = ^{sck_s, cs_rise_s, cs_fall_s, mosi_rise_s, mosi_fall_s, TO_LIMIT};

  spi_state_e        state_r;
  spi_state_e        state_nxt_s;
  logic              frame_r;
  logic [2:0]        bit_cnt_r;
  logic [6:0]        shift_r;
  logic [BYTE_W-1:0] rx_byte_s;
  logic              byte_done_s;
  logic              emit_s;
  logic [1:0]        tgt_idx_r;
  logic              tgt_ok_r;
  logic              abort_s;
  logic              lock_s;

  logic [TARGETS-1:0] strobe_nxt_s;
  logic               start_nxt_s;
  logic [BYTE_W-1:0]  data_nxt_s;
  logic [BYTE_W-1:0]  tx_sel_s;
  logic [TARGETS-1:0] strobe_r;
  logic               start_r;
  logic [BYTE_W-1:0]  data_out_r;
  logic [BYTE_W-1:0]  tx_r;
  logic               miso_r;

  assign rx_byte_s   = {shift_r, mosi_s};
  assign byte_done_s = sck_rise_s && (bit_cnt_r == 3'd7) && (state_r != ST_IDLE);
  assign emit_s      = byte_done_s && !cs_n_s && !abort_s;

`ifdef MCU_SPI_TIMEOUT_EN
  logic [15:0] stall_cnt_r;
  logic        lock_r;

  // Stall watchdog: counts quiet cycles in an open frame, then locks out the bus until CS rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 16'd0;
      lock_r      <= 1'b0;
    end else begin
      if (cs_n_s || sck_rise_s || sck_fall_s) begin
        stall_cnt_r <= 16'd0;
      end else if ((state_r != ST_IDLE) && !abort_s) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if (cs_n_s) begin
        lock_r <= 1'b0;
      end else if (abort_s) begin
        lock_r <= 1'b1;
      end
    end
  end

  assign abort_s = (state_r != ST_IDLE) && (stall_cnt_r == TO_LIMIT);
  assign lock_s  = lock_r;
`else
  assign abort_s = 1'b0;
  assign lock_s  = 1'b0;
`endif

  // Frame state register; frame_active is registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      frame_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      frame_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state logic: CS high or a watchdog abort always closes the frame.
  always_comb begin
    state_nxt_s = state_r;
    if (cs_n_s || abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = lock_s ? ST_IDLE : ST_TARGET;
        ST_TARGET:  state_nxt_s = byte_done_s ? ST_CMD : ST_TARGET;
        ST_CMD:     state_nxt_s = byte_done_s ? ST_PAYLOAD : ST_CMD;
        ST_PAYLOAD: state_nxt_s = ST_PAYLOAD;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Receive shifter, bit counter and target latch; partial bytes die with the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
      tgt_idx_r <= 2'd0;
      tgt_ok_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) || cs_n_s || abort_s) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
      tgt_idx_r <= 2'd0;
      tgt_ok_r  <= 1'b0;
    end else if (sck_rise_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      shift_r   <= rx_byte_s[6:0];
      if ((state_r == ST_TARGET) && byte_done_s) begin
        tgt_idx_r <= rx_byte_s[1:0];
        tgt_ok_r  <= id_in_range(rx_byte_s, TARGETS);
      end
    end
  end

  // Output decode: strobe the selected target for each command/payload byte.
  always_comb begin
    strobe_nxt_s = '0;
    start_nxt_s  = 1'b0;
    data_nxt_s   = data_out_r;
    case (state_r)
      ST_CMD, ST_PAYLOAD: begin
        if (emit_s) begin
          data_nxt_s = rx_byte_s;
          for (int t = 0; t < TARGETS; t++) begin
            strobe_nxt_s[t] = tgt_ok_r && (tgt_idx_r == 2'(t));
          end
          start_nxt_s = tgt_ok_r && (state_r == ST_CMD);
        end else begin
          data_nxt_s = data_out_r;
        end
      end
      default: begin
        strobe_nxt_s = '0;
        start_nxt_s  = 1'b0;
        data_nxt_s   = data_out_r;
      end
    endcase
  end

  // Reply byte mux for the currently selected target.
  always_comb begin
    tx_sel_s = '0;
    for (int t = 0; t < TARGETS; t++) begin
      tx_sel_s = tx_sel_s | ({BYTE_W{tgt_idx_r == 2'(t)}} & target_din[BYTE_W*t +: BYTE_W]);
    end
  end

  // Registered outputs; the reply is captured in the strobe cycle and shifted on SCK falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_r   <= '0;
      start_r    <= 1'b0;
      data_out_r <= 8'h00;
      tx_r       <= 8'h00;
      miso_r     <= 1'b0;
    end else begin
      strobe_r   <= strobe_nxt_s;
      start_r    <= start_nxt_s;
      data_out_r <= data_nxt_s;
      if (state_r == ST_IDLE) begin
        tx_r   <= 8'h00;
        miso_r <= 1'b0;
      end else if (|strobe_r) begin
        tx_r <= tx_sel_s;
      end else if (sck_fall_s) begin
        miso_r <= tx_r[7];
        tx_r   <= {tx_r[6:0], 1'b0};
      end
    end
  end

  assign data_out       = data_out_r;
  assign data_in_strobe = strobe_r;
  assign data_in_start  = start_r;
  assign frame_active   = frame_r;
  assign spi.spi_miso   = miso_r;

endmodule
